mpa_road_player: RTL and testbench

MPA_ROAD_PLAYER -- requirements
Module: mpa_road_player

---
 rtl/mpa_road_player_pkg.sv | 14 +
 rtl/mpa_road_fifo.sv | 54 +++++
 rtl/mpa_road_player.sv | 128 ++++++++++++
 tb/tb_mpa_road_player.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpa_road_player_pkg.sv
// Shared definitions for the road word replay block.
// Defaults, port count and replay state encoding.
package mpa_road_player_pkg;

  localparam int RD_W_DEF  = 30;
  localparam int DEPTH_DEF = 16;
  localparam int N_PORTS   = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/mpa_road_fifo.sv
// Single-clock FIFO with occupancy count and full/empty flags.
// Storage is not reset; flushing clears only pointers and count.
module mpa_road_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr_ok;
  logic          rd_ok;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign rd_data_o = mem[rd_ptr_q];
  assign wr_ok     = wr_en_i && !full_o;
  assign rd_ok     = rd_en_i && !empty_o;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_ok && !rd_ok)
        cnt_q <= cnt_q + CW'(1);
      else if (!wr_ok && rd_ok)
        cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/mpa_road_player.sv
// Four-port road word buffer: load while idle, then replay
// every port in parallel and flag the end of the run.
module mpa_road_player
  import mpa_road_player_pkg::*;
#(
  parameter int RD_W  = RD_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_en,
  input  logic [1:0]         ld_port,
  input  logic [RD_W-1:0]    ld_data,
  input  logic               start,
  output logic               busy,
  output logic [N_PORTS-1:0] ovf,
  output logic [RD_W-1:0]    p0_road_data,
  output logic [RD_W-1:0]    p1_road_data,
  output logic [RD_W-1:0]    p2_road_data,
  output logic [RD_W-1:0]    p3_road_data,
  output logic               p0_road_dv,
  output logic               p1_road_dv,
  output logic               p2_road_dv,
  output logic               p3_road_dv,
  output logic               eor
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e             state_q;
  logic [N_PORTS-1:0] ovf_q;
  logic [N_PORTS-1:0] dv_q;
  logic               eor_q;
  logic [CW-1:0]      rem_q;
  logic [RD_W-1:0]    data_q [N_PORTS];

  logic               idle;
  logic [N_PORTS-1:0] wr_en;
  logic [N_PORTS-1:0] rd_en;
  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] empty;
  logic [RD_W-1:0]    head [N_PORTS];
  logic [CW-1:0]      cnt  [N_PORTS];
  logic [CW-1:0]      occ_max;

  assign idle = (state_q == S_IDLE);

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign wr_en[g] = idle && ld_en &&
                      (ld_port == 2'(g)) && !full[g];
    assign rd_en[g] = !idle && !empty[g];

    mpa_road_fifo #(
      .W     (RD_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (ld_data),
      .rd_en_i   (rd_en[g]),
      .rd_data_o (head[g]),
      .count_o   (cnt[g]),
      .full_o    (full[g]),
      .empty_o   (empty[g])
    );
  end

  // Run length includes a word written on the start edge itself.
  always_comb begin
    occ_max = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (cnt[i] + CW'(wr_en[i]) > occ_max)
        occ_max = cnt[i] + CW'(wr_en[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ovf_q   <= '0;
      dv_q    <= '0;
      eor_q   <= 1'b0;
      rem_q   <= '0;
      for (int i = 0; i < N_PORTS; i++)
        data_q[i] <= '0;
    end else begin
      eor_q <= 1'b0;
      dv_q  <= rd_en;
      for (int i = 0; i < N_PORTS; i++) begin
        if (rd_en[i]) data_q[i] <= head[i];
      end
      unique case (state_q)
        S_IDLE: begin
          if (ld_en && full[ld_port])
            ovf_q[ld_port] <= 1'b1;
          if (start) begin
            state_q <= S_PLAY;
            ovf_q   <= '0;
            rem_q   <= occ_max;
          end
        end
        S_PLAY: begin
          if (rem_q == '0) begin
            eor_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state_q == S_PLAY);
  assign ovf          = ovf_q;
  assign eor          = eor_q;
  assign p0_road_data = data_q[0];
  assign p1_road_data = data_q[1];
  assign p2_road_data = data_q[2];
  assign p3_road_data = data_q[3];
  assign p0_road_dv   = dv_q[0];
  assign p1_road_dv   = dv_q[1];
  assign p2_road_dv   = dv_q[2];
  assign p3_road_dv   = dv_q[3];

endmodule

// File: tb/tb_mpa_road_player.sv
// Randomised bench for mpa_road_player against a queue model
// of the four port buffers and the replay timeline.
module tb_mpa_road_player;

  localparam int RD_W  = 30;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ld_en;
  logic [1:0]      ld_port;
  logic [RD_W-1:0] ld_data;
  logic            start;
  logic            busy;
  logic [3:0]      ovf;
  logic [RD_W-1:0] p0_road_data, p1_road_data;
  logic [RD_W-1:0] p2_road_data, p3_road_data;
  logic            p0_road_dv, p1_road_dv;
  logic            p2_road_dv, p3_road_dv;
  logic            eor;

  logic [RD_W-1:0] rdat [4];
  logic [3:0]      rdv;

  logic [RD_W-1:0] mq [4][$];
  logic [RD_W-1:0] mlast [4];
  logic [3:0]      movf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpa_road_player #(
    .RD_W  (RD_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_en        (ld_en),
    .ld_port      (ld_port),
    .ld_data      (ld_data),
    .start        (start),
    .busy         (busy),
    .ovf          (ovf),
    .p0_road_data (p0_road_data),
    .p1_road_data (p1_road_data),
    .p2_road_data (p2_road_data),
    .p3_road_data (p3_road_data),
    .p0_road_dv   (p0_road_dv),
    .p1_road_dv   (p1_road_dv),
    .p2_road_dv   (p2_road_dv),
    .p3_road_dv   (p3_road_dv),
    .eor          (eor)
  );

  assign rdat[0] = p0_road_data;
  assign rdat[1] = p1_road_data;
  assign rdat[2] = p2_road_data;
  assign rdat[3] = p3_road_data;
  assign rdv = {p3_road_dv, p2_road_dv, p1_road_dv, p0_road_dv};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RD_W-1:0] rnd();
    return RD_W'($urandom);
  endfunction

  task automatic mdl_flush();
    for (int p = 0; p < 4; p++) begin
      mq[p].delete();
      mlast[p] = '0;
    end
    movf = '0;
  endtask

  task automatic mdl_load(input int p, input logic [RD_W-1:0] d);
    if (mq[p].size() < DEPTH) mq[p].push_back(d);
    else movf[p] = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eor"}, eor, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_dv"}, rdv, 0);
    for (int p = 0; p < 4; p++)
      chk($sformatf("%s_p%0d_data", tag, p), rdat[p], 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ld_en = 1'b0; start = 1'b0;
    ld_port = '0; ld_data = '0;
    mdl_flush();
    @(posedge clk); #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input int p, input logic [RD_W-1:0] d);
    ld_en = 1'b1; ld_port = 2'(p); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl_load(p, d);
  endtask

  task automatic play(input bit with_ld, input bit noise);
    int m;
    int lp;
    logic [RD_W-1:0] ld;
    logic edv;
    chk("ovf_pre", ovf, movf);
    start = 1'b1;
    if (with_ld) begin
      lp = $urandom_range(0, 3);
      ld = rnd();
      ld_en = 1'b1; ld_port = 2'(lp); ld_data = ld;
      mdl_load(lp, ld);
    end
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    movf = '0;
    m = 0;
    for (int p = 0; p < 4; p++)
      if (mq[p].size() > m) m = mq[p].size();
    chk("busy_e0", busy, 1);
    chk("ovf_e0", ovf, 0);
    chk("eor_e0", eor, 0);
    for (int k = 1; k <= m + 1; k++) begin
      if (noise) begin
        start = 1'($urandom);
        ld_en = 1'b1; ld_port = 2'd3; ld_data = rnd();
      end
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        edv = (mq[p].size() > 0);
        if (edv) mlast[p] = mq[p].pop_front();
        chk($sformatf("p%0d_dv_e%0d", p, k), rdv[p], edv);
        chk($sformatf("p%0d_data_e%0d", p, k), rdat[p], mlast[p]);
      end
      chk($sformatf("eor_e%0d", k), eor, (k == m + 1));
      chk($sformatf("busy_e%0d", k), busy, (k <= m));
    end
    start = 1'b0; ld_en = 1'b0;
    @(posedge clk); #1;
    chk("eor_post", eor, 0);
    chk("dv_post", rdv, 0);
    chk("busy_post", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RD_W-1:0] w0;
    do_reset();

    load(0, 30'h0000001);
    load(0, 30'h0000002);
    load(0, 30'h0000003);
    load(2, 30'h3FFFFFF);
    play(0, 1);

    play(0, 0);

    for (int i = 0; i < 17; i++) load(1, RD_W'(i + 100));
    chk("ovf_17", ovf, 4'b0010);
    play(0, 0);

    load(3, rnd());
    load(3, rnd());
    play(1, 0);

    // Abort a replay part way through with reset.
    w0 = rnd();
    load(0, w0);
    for (int i = 0; i < 4; i++) load(0, rnd());
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_dv_e1", rdv[0], 1);
    chk("abort_data_e1", rdat[0], w0);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    mdl_flush();
    chk_zero("abort");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_eor", eor, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    play(0, 0);

    for (int r = 0; r < 12; r++) begin
      int nl;
      nl = $urandom_range(0, 40);
      for (int i = 0; i < nl; i++)
        load((r % 3 == 0) ? 1 : int'($urandom_range(0, 3)), rnd());
      play(1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
